// File: rtl/pcpu_int_ctrl_pkg.sv
// Shared definitions for the PCPU interrupt controller: handler states,
// default vector addresses and request source indices.
package pcpu_int_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF  = 32;
    localparam logic [31:0] VEC_ONE_DEF = 32'h0000_0040;
    localparam logic [31:0] VEC_TWO_DEF = 32'h0000_0080;

    // Bit positions of each source in the {two,one} status vectors
    localparam int unsigned SRC_ONE = 0;
    localparam int unsigned SRC_TWO = 1;

    // Which handler(s) are currently running
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SVC2  = 2'd1,
        ST_SVC1  = 2'd2,
        ST_SVC12 = 2'd3
    } int_state_e;

endpackage

// File: rtl/pcpu_int_ctrl_if.sv
// Interrupt controller <-> CPU pipeline signal bundle.
// master = CPU/pipeline side, slave = interrupt controller.
interface pcpu_int_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              interrupt_one;
    logic              interrupt_two;
    logic              int_en;
    logic              pipe_ready;
    logic [ADDR_W-1:0] resume_pc;
    logic              eret;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [1:0]        irq_ack;
    logic [1:0]        in_service;
    logic [1:0]        pending;
    logic [ADDR_W-1:0] epc_top;

    modport master (
        output interrupt_one, interrupt_two, int_en, pipe_ready, resume_pc, eret,
        input  redirect, redirect_pc, irq_ack, in_service, pending, epc_top
    );

    modport slave (
        input  interrupt_one, interrupt_two, int_en, pipe_ready, resume_pc, eret,
        output redirect, redirect_pc, irq_ack, in_service, pending, epc_top
    );
endinterface

// File: rtl/pcpu_int_ctrl_irq_edge_latch.sv
// Per-source rising-edge detector with a sticky pending flag.
// A new rise in the same cycle as a take keeps the request pending.
module irq_edge_latch (
    input  logic clk_i,
    input  logic rst_i,
    input  logic irq_i,
    input  logic take_i,
    output logic pending_o
);
    logic prev_q;
    logic pending_q, pending_d;
    logic rise;

    // Rise detect and pending set/clear
    always_comb begin
        rise      = irq_i & ~prev_q;
        pending_d = rise | (pending_q & ~take_i);
    end

    // Reset loads the current level so a line held high across reset is not a request
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q    <= irq_i;
            pending_q <= 1'b0;
        end else begin
            prev_q    <= irq_i;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;
endmodule

// File: rtl/pcpu_int_ctrl.sv
// Two-source prioritized interrupt controller beside the PCPU IF stage.
// Holds the handler FSM, priority select, 2-deep EPC stack and the
// registered redirect outputs.
module pcpu_int_ctrl
    import pcpu_int_ctrl_pkg::*;
#(
    parameter int unsigned       ADDR_W  = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] VEC_ONE = ADDR_W'(VEC_ONE_DEF),
    parameter logic [ADDR_W-1:0] VEC_TWO = ADDR_W'(VEC_TWO_DEF)
) (
    input  logic            clk_cpu,
    input  logic            rst,
    pcpu_int_ctrl_if.slave  bus
);
    int_state_e        state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [ADDR_W-1:0] epc0_q, epc1_q;
    logic [ADDR_W-1:0] epc_top;
    logic              redirect_q, redirect_d;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
    logic [1:0]        irq_ack_q, irq_ack_d;
    logic [1:0]        pend;
    logic              take_one, take_two, push;
    logic              eret_v, can_take;

    irq_edge_latch u_edge_one (
        .clk_i     (clk_cpu),
        .rst_i     (rst),
        .irq_i     (bus.interrupt_one),
        .take_i    (take_one),
        .pending_o (pend[SRC_ONE])
    );

    irq_edge_latch u_edge_two (
        .clk_i     (clk_cpu),
        .rst_i     (rst),
        .irq_i     (bus.interrupt_two),
        .take_i    (take_two),
        .pending_o (pend[SRC_TWO])
    );

    // Top-of-stack view, also the return target for eret
    always_comb begin
        case (ptr_q)
            2'd1:    epc_top = epc0_q;
            2'd2:    epc_top = epc1_q;
            default: epc_top = '0;
        endcase
    end

    // Priority select and next-state/output decode; eret beats any new take.
    // eret is not honoured in the blackout cycle so redirect can never pulse
    // back-to-back (the pipeline is flushed then, so no eret can be in EX).
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        redirect_d    = 1'b0;
        redirect_pc_d = '0;
        irq_ack_d     = 2'b00;
        push          = 1'b0;

        eret_v   = bus.eret & ~redirect_q & (state_q != ST_IDLE);
        can_take = bus.int_en & bus.pipe_ready & ~redirect_q & ~bus.eret;
        take_one = can_take & pend[SRC_ONE] &
                   ((state_q == ST_IDLE) || (state_q == ST_SVC2));
        take_two = can_take & pend[SRC_TWO] & (state_q == ST_IDLE) & ~take_one;

        if (eret_v) begin
            redirect_d    = 1'b1;
            redirect_pc_d = epc_top;
            ptr_d         = ptr_q - 2'd1;
            state_d       = (state_q == ST_SVC12) ? ST_SVC2 : ST_IDLE;
        end else if (take_one) begin
            redirect_d    = 1'b1;
            redirect_pc_d = VEC_ONE;
            irq_ack_d     = 2'b01;
            ptr_d         = ptr_q + 2'd1;
            push          = 1'b1;
            state_d       = (state_q == ST_SVC2) ? ST_SVC12 : ST_SVC1;
        end else if (take_two) begin
            redirect_d    = 1'b1;
            redirect_pc_d = VEC_TWO;
            irq_ack_d     = 2'b10;
            ptr_d         = ptr_q + 2'd1;
            push          = 1'b1;
            state_d       = ST_SVC2;
        end
    end

    // FSM state and stack pointer
    always_ff @(posedge clk_cpu) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // EPC stack entries: push writes the slot selected by the current pointer
    always_ff @(posedge clk_cpu) begin
        if (rst) begin
            epc0_q <= '0;
            epc1_q <= '0;
        end else if (push) begin
            if (ptr_q == 2'd0) epc0_q <= bus.resume_pc;
            else               epc1_q <= bus.resume_pc;
        end
    end

    // Registered redirect / acknowledge outputs
    always_ff @(posedge clk_cpu) begin
        if (rst) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            irq_ack_q     <= 2'b00;
        end else begin
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            irq_ack_q     <= irq_ack_d;
        end
    end

    // in_service mirrors the handler state as {two,one}
    always_comb begin
        case (state_q)
            ST_SVC2:  bus.in_service = 2'b10;
            ST_SVC1:  bus.in_service = 2'b01;
            ST_SVC12: bus.in_service = 2'b11;
            default:  bus.in_service = 2'b00;
        endcase
    end

    assign bus.redirect    = redirect_q;
    assign bus.redirect_pc = redirect_pc_q;
    assign bus.irq_ack     = irq_ack_q;
    assign bus.pending     = pend;
    assign bus.epc_top     = epc_top;
endmodule
